// File: rtl/regfile_pkg.sv
// Shared state encoding for the multi-port register file.
package regfile_pkg;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: clear masking, zero register, write bypass, array read.
module rf_read_port #(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = 31
) (
    input  logic              isClear,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [DATA_W-1:0] rowData,
    input  logic              wr0Commit,
    input  logic [ADDR_W-1:0] rw0,
    input  logic [DATA_W-1:0] busW0,
    input  logic              wr1Commit,
    input  logic [ADDR_W-1:0] rw1,
    input  logic [DATA_W-1:0] busW1,
    output logic [DATA_W-1:0] rdData
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

    // Commit qualifiers already exclude CLEAR, Flush and zero-register writes.
    always_comb begin
        rdData = rowData;
        if (isClear) begin
            rdData = '0;
        end else if ((HAS_ZERO != 0) && (rdAddr == ZERO_ADDR)) begin
            rdData = '0;
        end else if (wr1Commit && (rw1 == rdAddr)) begin
            rdData = busW1;
        end else if (wr0Commit && (rw0 == rdAddr)) begin
            rdData = busW0;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD bypassed read ports, two write ports, clear sweep
// after reset or Flush, optional hardwired zero register.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int HAS_ZERO = 1,
    parameter int ZERO_IDX = 31
) (
    input  logic                     Clk,
    input  logic                     ResetL,
    input  logic                     Flush,
    output logic                     Ready,
    input  logic [NUM_RD*ADDR_W-1:0] RA,
    output logic [NUM_RD*DATA_W-1:0] Bus,
    input  logic                     RegWr0,
    input  logic [ADDR_W-1:0]        RW0,
    input  logic [DATA_W-1:0]        BusW0,
    input  logic                     RegWr1,
    input  logic [ADDR_W-1:0]        RW1,
    input  logic [DATA_W-1:0]        BusW1
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clrIdx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              run;
    logic              wr0Commit;
    logic              wr1Commit;

    assign run   = (state == ST_RUN);
    assign Ready = run;

    assign wr0Commit = run && !Flush && RegWr0 && !((HAS_ZERO != 0) && (RW0 == ZERO_ADDR));
    assign wr1Commit = run && !Flush && RegWr1 && !((HAS_ZERO != 0) && (RW1 == ZERO_ADDR));

    always_ff @(posedge Clk or negedge ResetL) begin
        if (!ResetL) begin
            state  <= ST_CLEAR;
            clrIdx <= '0;
        end else if (state == ST_CLEAR) begin
            clrIdx <= clrIdx + 1'b1;
            if (clrIdx == ADDR_W'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end else if (Flush) begin
            state  <= ST_CLEAR;
            clrIdx <= '0;
        end
    end

    // Storage needs no reset: the sweep defines every entry before RUN.
    always_ff @(posedge Clk) begin
        if (!run) begin
            mem[clrIdx] <= '0;
        end else begin
            if (wr0Commit && !(wr1Commit && (RW1 == RW0))) begin
                mem[RW0] <= BusW0;
            end
            if (wr1Commit) begin
                mem[RW1] <= BusW1;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRead
        logic [ADDR_W-1:0] addr;
        assign addr = RA[i*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .HAS_ZERO(HAS_ZERO),
            .ZERO_IDX(ZERO_IDX)
        ) uPort (
            .isClear  (!run),
            .rdAddr   (addr),
            .rowData  (mem[addr]),
            .wr0Commit(wr0Commit),
            .rw0      (RW0),
            .busW0    (BusW0),
            .wr1Commit(wr1Commit),
            .rw1      (RW1),
            .busW1    (BusW1),
            .rdData   (Bus[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a queue of expected read-port values.
module tb_regfile_mp;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             Clk = 1'b0;
    logic             ResetL;
    logic             Flush;
    logic             Ready;
    logic [NR*AW-1:0] RA;
    logic [NR*DW-1:0] Bus;
    logic             RegWr0;
    logic [AW-1:0]    RW0;
    logic [DW-1:0]    BusW0;
    logic             RegWr1;
    logic [AW-1:0]    RW1;
    logic [DW-1:0]    BusW1;

    typedef struct {
        string       tag;
        int          port;
        logic [63:0] val;
    } exp_t;

    exp_t expQ[$];
    int   checkCnt = 0;
    int   passCnt  = 0;
    int   failCnt  = 0;

    localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0000_0001;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .HAS_ZERO(1), .ZERO_IDX(31)) dut (
        .Clk   (Clk),
        .ResetL(ResetL),
        .Flush (Flush),
        .Ready (Ready),
        .RA    (RA),
        .Bus   (Bus),
        .RegWr0(RegWr0),
        .RW0   (RW0),
        .BusW0 (BusW0),
        .RegWr1(RegWr1),
        .RW1   (RW1),
        .BusW1 (BusW1)
    );

    always #5 Clk = ~Clk;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expBus(input string tag, input int port, input logic [63:0] val);
        exp_t e;
        e.tag  = tag;
        e.port = port;
        e.val  = val;
        expQ.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal(e.tag, Bus[e.port*DW +: DW], e.val);
        end
    endtask

    task automatic setRA(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        RA = {a1, a0};
    endtask

    // Counts posedges until Ready; optionally pulses Flush (must be ignored) mid-sweep.
    task automatic waitReady(output int n, output bit busZero, input int flushAt);
        n       = 0;
        busZero = 1'b1;
        while (1) begin
            @(posedge Clk);
            #1;
            n++;
            Flush = (n == flushAt);
            if (Ready) break;
            if (Bus !== '0) busZero = 1'b0;
            if (n >= 200) break;
        end
        Flush = 1'b0;
    endtask

    initial begin
        int n;
        bit ok;

        ResetL = 1'b0; Flush = 1'b0;
        RegWr0 = 1'b0; RW0 = '0; BusW0 = '0;
        RegWr1 = 1'b0; RW1 = '0; BusW1 = '0;
        setRA(5'd1, 5'd0);
        repeat (2) @(negedge Clk);
        #1;
        checkVal("rst_ready", {63'b0, Ready}, 64'd0);
        expBus("rst_bus0", 0, 64'd0);
        expBus("rst_bus1", 1, 64'd0);
        drain();

        // Release reset with a write held active: the sweep must ignore it.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd3; BusW0 = 64'h1234;
        setRA(5'd3, 5'd7);
        ResetL = 1'b1;
        waitReady(n, ok, 0);
        checkVal("sweep_len", 64'(n), 64'd32);
        checkVal("sweep_bus_zero", {63'b0, ok}, 64'd1);
        RegWr0 = 1'b0;

        @(negedge Clk);
        setRA(5'd3, 5'd4);
        #1;
        expBus("clr_r3", 0, 64'd0);
        expBus("clr_r4", 1, 64'd0);
        drain();

        // Basic write with same-cycle bypass, then stored read.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd3; BusW0 = DEAD;
        setRA(5'd3, 5'd4);
        #1;
        expBus("wr_byp_r3", 0, DEAD);
        expBus("wr_byp_r4", 1, 64'd0);
        drain();
        @(negedge Clk);
        RegWr0 = 1'b0;
        #1;
        expBus("rd_r3", 0, DEAD);
        expBus("rd_r4", 1, 64'd0);
        drain();

        // Bypass on both read ports of one address.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd7; BusW0 = 64'h55;
        setRA(5'd7, 5'd7);
        #1;
        expBus("byp7_p0", 0, 64'h55);
        expBus("byp7_p1", 1, 64'h55);
        drain();
        @(negedge Clk);
        RegWr0 = 1'b0;
        setRA(5'd7, 5'd3);
        #1;
        expBus("rd_r7", 0, 64'h55);
        expBus("rd_r3_again", 1, DEAD);
        drain();

        // Collision: port 1 wins both bypass and storage.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd9; BusW0 = 64'h1;
        RegWr1 = 1'b1; RW1 = 5'd9; BusW1 = 64'h2;
        setRA(5'd9, 5'd9);
        #1;
        expBus("coll_byp_p0", 0, 64'h2);
        expBus("coll_byp_p1", 1, 64'h2);
        drain();
        @(negedge Clk);
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        #1;
        expBus("coll_store", 0, 64'h2);
        drain();

        // Port 1 alone into a different register than port 0.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd10; BusW0 = 64'hAA;
        RegWr1 = 1'b1; RW1 = 5'd11; BusW1 = 64'hBB;
        setRA(5'd10, 5'd11);
        #1;
        expBus("dual_byp10", 0, 64'hAA);
        expBus("dual_byp11", 1, 64'hBB);
        drain();
        @(negedge Clk);
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        #1;
        expBus("dual_rd10", 0, 64'hAA);
        expBus("dual_rd11", 1, 64'hBB);
        drain();

        // Zero register ignores writes from both ports.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd31; BusW0 = '1;
        RegWr1 = 1'b1; RW1 = 5'd31; BusW1 = '1;
        setRA(5'd31, 5'd3);
        #1;
        expBus("zero_same", 0, 64'd0);
        expBus("zero_other", 1, DEAD);
        drain();
        @(negedge Clk);
        RegWr0 = 1'b0; RegWr1 = 1'b0;
        setRA(5'd31, 5'd31);
        #1;
        expBus("zero_later_p0", 0, 64'd0);
        expBus("zero_later_p1", 1, 64'd0);
        drain();

        // Flush cycle: no bypass, no write, normal reads.
        @(negedge Clk);
        Flush = 1'b1;
        RegWr0 = 1'b1; RW0 = 5'd5; BusW0 = 64'hA;
        setRA(5'd5, 5'd3);
        #1;
        checkVal("flush_ready_pre", {63'b0, Ready}, 64'd1);
        expBus("flush_r5", 0, 64'd0);
        expBus("flush_r3", 1, DEAD);
        drain();
        @(posedge Clk);
        #1;
        Flush = 1'b0;
        RW0 = 5'd3; BusW0 = 64'h77;
        checkVal("flush_ready_post", {63'b0, Ready}, 64'd0);
        waitReady(n, ok, 5);
        checkVal("flush_sweep_len", 64'(n), 64'd32);
        checkVal("flush_bus_zero", {63'b0, ok}, 64'd1);
        RegWr0 = 1'b0;
        @(negedge Clk);
        setRA(5'd5, 5'd3);
        #1;
        expBus("post_flush_r5", 0, 64'd0);
        expBus("post_flush_r3", 1, 64'd0);
        drain();

        // Reset ten cycles into a sweep restarts the full count.
        @(negedge Clk);
        RegWr0 = 1'b1; RW0 = 5'd12; BusW0 = 64'hC;
        @(negedge Clk);
        RegWr0 = 1'b0;
        Flush = 1'b1;
        @(negedge Clk);
        Flush = 1'b0;
        repeat (9) @(negedge Clk);
        ResetL = 1'b0;
        #1;
        checkVal("midrst_ready", {63'b0, Ready}, 64'd0);
        @(negedge Clk);
        ResetL = 1'b1;
        waitReady(n, ok, 0);
        checkVal("midrst_sweep_len", 64'(n), 64'd32);
        @(negedge Clk);
        setRA(5'd12, 5'd9);
        #1;
        expBus("midrst_r12", 0, 64'd0);
        expBus("midrst_r9", 1, 64'd0);
        drain();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
